// File: rtl/operand_ready_stage.sv
`default_nettype none
// ============================================================================
// operand_ready_stage : single-entry decode->issue hold stage that waits for
//                       GPR busy bits to clear. Optional stall counter is
//                       enabled by defining OPERAND_STALL_COUNT_EN.
// Revision: 1.0
// ============================================================================
`ifndef OPERAND_LENGTH_4WORD
`define OPERAND_LENGTH_4WORD 12
`endif
`ifndef OPERAND_LENGTH_2WORD
`define OPERAND_LENGTH_2WORD 12
`endif

module operand_ready_stage #(
    parameter int WFID_W      = 6,
    parameter int STALL_CNT_W = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             decode_valid,
    output logic                             decode_ready,
    input  logic [WFID_W-1:0]                decode_wfid,
    input  logic [`OPERAND_LENGTH_4WORD-1:0] decode_dest_reg1,
    input  logic [`OPERAND_LENGTH_2WORD-1:0] decode_dest_reg2,
    input  logic [`OPERAND_LENGTH_4WORD-1:0] decode_source_reg1,
    input  logic [`OPERAND_LENGTH_2WORD-1:0] decode_source_reg2,
    input  logic [`OPERAND_LENGTH_2WORD-1:0] decode_source_reg3,
    input  logic [`OPERAND_LENGTH_4WORD-1:0] decode_source_reg4,
    output logic [`OPERAND_LENGTH_4WORD-1:0] f_decode_dest_reg1,
    output logic [`OPERAND_LENGTH_2WORD-1:0] f_decode_dest_reg2,
    output logic [`OPERAND_LENGTH_4WORD-1:0] f_decode_source_reg1,
    output logic [`OPERAND_LENGTH_2WORD-1:0] f_decode_source_reg2,
    output logic [`OPERAND_LENGTH_2WORD-1:0] f_decode_source_reg3,
    output logic [`OPERAND_LENGTH_4WORD-1:0] f_decode_source_reg4,
    input  logic [3:0]                       decode_dest_reg1_busy_bits,
    input  logic [1:0]                       decode_dest_reg2_busy_bits,
    input  logic [3:0]                       decode_source_reg1_busy_bits,
    input  logic [1:0]                       decode_source_reg2_busy_bits,
    input  logic [1:0]                       decode_source_reg3_busy_bits,
    input  logic [3:0]                       decode_source_reg4_busy_bits,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output logic [WFID_W-1:0]                issue_wfid,
    output logic [`OPERAND_LENGTH_4WORD-1:0] issue_dest_reg1,
    output logic [`OPERAND_LENGTH_2WORD-1:0] issue_dest_reg2,
    output logic [`OPERAND_LENGTH_4WORD-1:0] issue_source_reg1,
    output logic [`OPERAND_LENGTH_2WORD-1:0] issue_source_reg2,
    output logic [`OPERAND_LENGTH_2WORD-1:0] issue_source_reg3,
    output logic [`OPERAND_LENGTH_4WORD-1:0] issue_source_reg4,
    input  logic                             flush_valid,
    input  logic [WFID_W-1:0]                flush_wfid,
    output logic [STALL_CNT_W-1:0]           stall_cycles
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WFID_W-1:0]                r_wfid;
    logic [`OPERAND_LENGTH_4WORD-1:0] r_dest_reg1;
    logic [`OPERAND_LENGTH_2WORD-1:0] r_dest_reg2;
    logic [`OPERAND_LENGTH_4WORD-1:0] r_source_reg1;
    logic [`OPERAND_LENGTH_2WORD-1:0] r_source_reg2;
    logic [`OPERAND_LENGTH_2WORD-1:0] r_source_reg3;
    logic [`OPERAND_LENGTH_4WORD-1:0] r_source_reg4;

    logic w_any_busy;
    logic w_flush_hit;
    logic w_issue_fire;
    logic w_capture;
    logic w_drop;
    logic w_load;

    assign w_any_busy = (|decode_dest_reg1_busy_bits)   | (|decode_dest_reg2_busy_bits)   |
                        (|decode_source_reg1_busy_bits) | (|decode_source_reg2_busy_bits) |
                        (|decode_source_reg3_busy_bits) | (|decode_source_reg4_busy_bits);

    assign w_flush_hit  = flush_valid && (r_state != S_EMPTY) && (flush_wfid == r_wfid);
    assign w_issue_fire = (r_state == S_ISSUE) && issue_ready && !w_flush_hit;
    assign w_capture    = decode_valid && decode_ready;
    // An instruction arriving together with a flush of its own wavefront is never held.
    assign w_drop       = w_capture && flush_valid && (flush_wfid == decode_wfid);
    assign w_load       = w_capture && !w_drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        decode_ready = 1'b0;
        issue_valid  = 1'b0;
        case (r_state)
            S_EMPTY: begin
                decode_ready = 1'b1;
                if (w_load) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_any_busy) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                issue_valid  = !w_flush_hit;
                decode_ready = w_issue_fire;
                if (w_issue_fire) begin
                    w_state_nxt = w_load ? S_WAIT : S_EMPTY;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
        if (w_flush_hit) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wfid        <= '0;
            r_dest_reg1   <= '0;
            r_dest_reg2   <= '0;
            r_source_reg1 <= '0;
            r_source_reg2 <= '0;
            r_source_reg3 <= '0;
            r_source_reg4 <= '0;
        end else if (w_load) begin
            r_wfid        <= decode_wfid;
            r_dest_reg1   <= decode_dest_reg1;
            r_dest_reg2   <= decode_dest_reg2;
            r_source_reg1 <= decode_source_reg1;
            r_source_reg2 <= decode_source_reg2;
            r_source_reg3 <= decode_source_reg3;
            r_source_reg4 <= decode_source_reg4;
        end
    end

    assign f_decode_dest_reg1   = r_dest_reg1;
    assign f_decode_dest_reg2   = r_dest_reg2;
    assign f_decode_source_reg1 = r_source_reg1;
    assign f_decode_source_reg2 = r_source_reg2;
    assign f_decode_source_reg3 = r_source_reg3;
    assign f_decode_source_reg4 = r_source_reg4;

    assign issue_wfid        = r_wfid;
    assign issue_dest_reg1   = r_dest_reg1;
    assign issue_dest_reg2   = r_dest_reg2;
    assign issue_source_reg1 = r_source_reg1;
    assign issue_source_reg2 = r_source_reg2;
    assign issue_source_reg3 = r_source_reg3;
    assign issue_source_reg4 = r_source_reg4;

`ifdef OPERAND_STALL_COUNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Counts busy cycles of the current hold only; saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_capture) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_WAIT) && w_any_busy && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_operand_ready_stage.sv
`default_nettype none
// ============================================================================
// tb_operand_ready_stage : directed + randomized bench with a slot-level model.
// Revision: 1.0
// ============================================================================
`ifndef OPERAND_LENGTH_4WORD
`define OPERAND_LENGTH_4WORD 12
`endif
`ifndef OPERAND_LENGTH_2WORD
`define OPERAND_LENGTH_2WORD 12
`endif

module tb_operand_ready_stage;

    localparam int WFID_W  = 6;
    localparam int SCW     = 4;
    localparam int OP4     = `OPERAND_LENGTH_4WORD;
    localparam int OP2     = `OPERAND_LENGTH_2WORD;
    localparam int CNT_MAX = (1 << SCW) - 1;
`ifdef OPERAND_STALL_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              decode_valid = 1'b0;
    logic              decode_ready;
    logic [WFID_W-1:0] decode_wfid = '0;
    logic [OP4-1:0]    d_dest1 = '0, d_src1 = '0, d_src4 = '0;
    logic [OP2-1:0]    d_dest2 = '0, d_src2 = '0, d_src3 = '0;
    logic [OP4-1:0]    f_dest1, f_src1, f_src4, i_dest1, i_src1, i_src4;
    logic [OP2-1:0]    f_dest2, f_src2, f_src3, i_dest2, i_src2, i_src3;
    logic [3:0]        b_dest1 = '0, b_src1 = '0, b_src4 = '0;
    logic [1:0]        b_dest2 = '0, b_src2 = '0, b_src3 = '0;
    logic              issue_valid;
    logic              issue_ready = 1'b0;
    logic [WFID_W-1:0] issue_wfid;
    logic              flush_valid = 1'b0;
    logic [WFID_W-1:0] flush_wfid = '0;
    logic [SCW-1:0]    stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_ready_stage #(.WFID_W(WFID_W), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .rst(rst),
        .decode_valid(decode_valid), .decode_ready(decode_ready), .decode_wfid(decode_wfid),
        .decode_dest_reg1(d_dest1), .decode_dest_reg2(d_dest2),
        .decode_source_reg1(d_src1), .decode_source_reg2(d_src2),
        .decode_source_reg3(d_src3), .decode_source_reg4(d_src4),
        .f_decode_dest_reg1(f_dest1), .f_decode_dest_reg2(f_dest2),
        .f_decode_source_reg1(f_src1), .f_decode_source_reg2(f_src2),
        .f_decode_source_reg3(f_src3), .f_decode_source_reg4(f_src4),
        .decode_dest_reg1_busy_bits(b_dest1), .decode_dest_reg2_busy_bits(b_dest2),
        .decode_source_reg1_busy_bits(b_src1), .decode_source_reg2_busy_bits(b_src2),
        .decode_source_reg3_busy_bits(b_src3), .decode_source_reg4_busy_bits(b_src4),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_wfid(issue_wfid),
        .issue_dest_reg1(i_dest1), .issue_dest_reg2(i_dest2),
        .issue_source_reg1(i_src1), .issue_source_reg2(i_src2),
        .issue_source_reg3(i_src3), .issue_source_reg4(i_src4),
        .flush_valid(flush_valid), .flush_wfid(flush_wfid), .stall_cycles(stall_cycles)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one slot that is either empty or holds an instruction which has or
    // has not yet passed a busy-free cycle; fields persist after the slot empties.
    bit              m_held, m_cleared;
    int              m_cnt;
    logic [WFID_W-1:0] m_wfid;
    logic [OP4-1:0]  m_d1, m_s1, m_s4;
    logic [OP2-1:0]  m_d2, m_s2, m_s3;
    bit              fh, e_iv, e_dr, busy, acc, cap, drop, w_busy, w_clear;

    always @(negedge clk) begin
        if (!rst) begin
            m_held = 0; m_cleared = 0; m_cnt = 0; m_wfid = '0;
            m_d1 = '0; m_d2 = '0; m_s1 = '0; m_s2 = '0; m_s3 = '0; m_s4 = '0;
            check("rst_decode_ready", decode_ready, 1);
            check("rst_issue_valid", issue_valid, 0);
            check("rst_issue_wfid", issue_wfid, 0);
            check("rst_f_dest1", f_dest1, 0);
            check("rst_i_src4", i_src4, 0);
            check("rst_stall", stall_cycles, 0);
        end else begin
            busy = (|b_dest1) | (|b_dest2) | (|b_src1) | (|b_src2) | (|b_src3) | (|b_src4);
            fh   = m_held && flush_valid && (flush_wfid == m_wfid);
            e_iv = m_held && m_cleared && !fh;
            e_dr = !m_held || (e_iv && issue_ready);
            check("m_decode_ready", decode_ready, e_dr);
            check("m_issue_valid", issue_valid, e_iv);
            check("m_issue_wfid", issue_wfid, m_wfid);
            check("m_fields_f", {f_dest1, f_dest2, f_src1}, {m_d1, m_d2, m_s1});
            check("m_fields_f2", {f_src2, f_src3, f_src4}, {m_s2, m_s3, m_s4});
            check("m_fields_i", {i_dest1, i_dest2, i_src1}, {m_d1, m_d2, m_s1});
            check("m_fields_i2", {i_src2, i_src3, i_src4}, {m_s2, m_s3, m_s4});
            check("m_stall", stall_cycles, CNT_EN ? m_cnt : 0);
            w_busy  = m_held && !m_cleared && busy;
            w_clear = m_held && !m_cleared && !busy;
            acc  = e_iv && issue_ready;
            cap  = decode_valid && e_dr;
            drop = cap && flush_valid && (flush_wfid == decode_wfid);
            if (w_busy && m_cnt != CNT_MAX) m_cnt++;
            if (fh || acc) m_held = 0;
            else if (w_clear) m_cleared = 1;
            if (cap) begin
                m_cnt = 0;
                if (!drop) begin
                    m_held = 1; m_cleared = 0; m_wfid = decode_wfid;
                    m_d1 = d_dest1; m_d2 = d_dest2; m_s1 = d_src1;
                    m_s2 = d_src2; m_s3 = d_src3; m_s4 = d_src4;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        repeat (2) smp();
        check("reset_dready", decode_ready, 1);
        check("reset_iv", issue_valid, 0);
        tick(); rst = 1'b1;

        // back-to-back, no hazards
        tick(); decode_valid = 1; decode_wfid = 3; d_dest1 = 12'h123; d_src2 = 12'h0a5; issue_ready = 1;
        smp(); check("b2b_cap_dready", decode_ready, 1);
        tick(); decode_valid = 0;
        smp(); check("b2b_wait_iv", issue_valid, 0);
        tick(); decode_valid = 1; decode_wfid = 4; d_dest1 = 12'h456;
        smp(); check("b2b_iv1", issue_valid, 1); check("b2b_wfid1", issue_wfid, 3);
        check("b2b_dest1", i_dest1, 12'h123); check("b2b_src2", i_src2, 12'h0a5);
        check("b2b_dready_issue", decode_ready, 1);
        tick(); decode_valid = 0;
        smp(); check("b2b_wait2_iv", issue_valid, 0);
        tick();
        smp(); check("b2b_iv2", issue_valid, 1); check("b2b_wfid2", issue_wfid, 4);
        check("b2b_dest1_2", f_dest1, 12'h456);
        tick(); issue_ready = 0;
        smp(); check("b2b_empty_iv", issue_valid, 0); check("b2b_empty_dr", decode_ready, 1);

        // source busy for five WAIT cycles, then backpressure
        tick(); decode_valid = 1; decode_wfid = 6; b_src2 = 2'b01;
        tick(); decode_valid = 0;
        repeat (4) tick();
        tick(); b_src2 = 2'b00;
        smp(); check("busy_clear_iv", issue_valid, 0);
        tick();
        smp(); check("busy_iv", issue_valid, 1); check("busy_stall", stall_cycles, CNT_EN ? 5 : 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            smp(); check("bp_iv", issue_valid, 1); check("bp_wfid", issue_wfid, 6);
            check("bp_dready", decode_ready, 0); check("bp_stall", stall_cycles, CNT_EN ? 5 : 0);
        end
        tick(); issue_ready = 1;
        smp(); check("bp_rel_dr", decode_ready, 1);
        tick(); issue_ready = 0;
        smp(); check("bp_empty_iv", issue_valid, 0); check("bp_empty_dr", decode_ready, 1);

        // non-matching then matching flush in ISSUE
        tick(); decode_valid = 1; decode_wfid = 7;
        tick(); decode_valid = 0;
        tick(); flush_valid = 1; flush_wfid = 2;
        smp(); check("flush_nm_iv", issue_valid, 1);
        tick(); flush_wfid = 7; issue_ready = 1;
        smp(); check("flush_iv", issue_valid, 0); check("flush_dr", decode_ready, 0);
        tick(); flush_valid = 0; issue_ready = 0;
        smp(); check("flush_empty_iv", issue_valid, 0); check("flush_empty_dr", decode_ready, 1);

        // capture dropped by same-cycle flush of its wavefront
        tick(); decode_valid = 1; decode_wfid = 5; flush_valid = 1; flush_wfid = 5;
        tick(); decode_valid = 0; flush_valid = 0;
        smp(); check("drop_dr", decode_ready, 1);
        tick();
        smp(); check("drop_iv", issue_valid, 0);

        // reset during WAIT
        tick(); decode_valid = 1; decode_wfid = 9; d_dest1 = 12'h7ff; b_src1 = 4'hf;
        tick(); decode_valid = 0;
        smp(); check("rw_dr", decode_ready, 0);
        tick(); rst = 0;
        smp(); check("rw_f_dest1", f_dest1, 0); check("rw_dr_rst", decode_ready, 1);
        tick(); rst = 1; b_src1 = 4'h0;

        // stall counter saturation
        tick(); decode_valid = 1; decode_wfid = 10; b_dest2 = 2'b10;
        tick(); decode_valid = 0;
        repeat (18) tick();
        tick(); b_dest2 = 2'b00;
        smp(); check("sat_stall", stall_cycles, CNT_EN ? CNT_MAX : 0);
        tick(); issue_ready = 1;
        tick(); issue_ready = 0;

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            tick();
            rst          = ($urandom_range(0, 499) != 0);
            decode_valid = ($urandom_range(0, 9) < 6);
            decode_wfid  = WFID_W'($urandom_range(1, 4));
            d_dest1 = OP4'($urandom); d_dest2 = OP2'($urandom); d_src1 = OP4'($urandom);
            d_src2  = OP2'($urandom); d_src3  = OP2'($urandom); d_src4 = OP4'($urandom);
            issue_ready = ($urandom_range(0, 9) < 7);
            flush_valid = ($urandom_range(0, 9) == 0);
            flush_wfid  = WFID_W'($urandom_range(1, 4));
            {b_dest1, b_dest2, b_src1, b_src2, b_src3, b_src4} = '0;
            if ($urandom_range(0, 9) < 4) begin
                case ($urandom_range(0, 5))
                    0: b_dest1 = 4'($urandom);
                    1: b_dest2 = 2'($urandom);
                    2: b_src1  = 4'($urandom);
                    3: b_src2  = 2'($urandom);
                    4: b_src3  = 2'($urandom);
                    default: b_src4 = 4'($urandom);
                endcase
            end
        end
        tick();
        rst = 1; decode_valid = 0; flush_valid = 0; issue_ready = 1;
        {b_dest1, b_dest2, b_src1, b_src2, b_src3, b_src4} = '0;
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
